// File: rtl/nvme_ucq_sq_fetch.sv
// nvme_ucq_sq_fetch: fetch sequencer for the microcode NVMe submission queue.
// Notices when the producer tail moves past the local fetch pointer, reads
// each 64B entry out of SQ memory as four 16B words, streams them to the
// command interface with first/last markers and byte-parity checking, then
// rings a single batched doorbell carrying the new tail.
module nvme_ucq_sq_fetch #(
    parameter int num_entries        = 4,
    parameter int sq_rdwidth         = 128,
    parameter int sq_par_rdwidth     = sq_rdwidth / 8,
    parameter int sq_words_per_entry = 4,
    parameter int sq_addr_width      = $clog2(num_entries * sq_words_per_entry),
    parameter int sq_ptr_width       = $clog2(num_entries)
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [sq_ptr_width-1:0]                sq_tail,
    input  logic                                   q_reset,
    input  logic                                   sq_wr_active,
    output logic [sq_addr_width-1:0]               sq_rdaddr,
    output logic                                   sq_rdval,
    input  logic [sq_par_rdwidth+sq_rdwidth-1:0]   sq_rddata,
    input  logic                                   sq_rddata_val,
    output logic                                   cmd_valid,
    input  logic                                   cmd_ready,
    output logic [sq_par_rdwidth+sq_rdwidth-1:0]   cmd_data,
    output logic                                   cmd_first,
    output logic                                   cmd_last,
    output logic                                   db_req,
    output logic [sq_ptr_width-1:0]                db_tail,
    input  logic                                   db_ack,
    output logic [sq_ptr_width-1:0]                fetch_ptr,
    output logic                                   busy,
    output logic                                   par_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_DOORBELL = 3'd4;

    localparam logic [1:0] last_word = 2'(sq_words_per_entry - 1);

    logic [2:0]                                state_q, state_d;
    logic [1:0]                                word_idx_q, word_idx_d;
    logic [sq_ptr_width-1:0]                   fetch_ptr_q, fetch_ptr_d;
    logic [sq_ptr_width-1:0]                   fetch_ptr_inc;
    logic [sq_par_rdwidth+sq_rdwidth-1:0]      cmd_data_q, cmd_data_d;
    logic                                      par_err_q, par_err_d;
    logic                                      par_bad;

    // Odd parity per byte: each byte plus its parity bit must hold an odd number of ones.
    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < sq_par_rdwidth; i++) begin
            if (!(^{sq_rddata[sq_rdwidth + i], sq_rddata[8*i +: 8]})) begin
                par_bad = 1'b1;
            end
        end
    end

    assign fetch_ptr_inc = fetch_ptr_q + 1'b1;

    // Next-state logic for the fetch sequencer; q_reset overrides everything.
    always_comb begin
        state_d     = state_q;
        word_idx_d  = word_idx_q;
        fetch_ptr_d = fetch_ptr_q;
        cmd_data_d  = cmd_data_q;
        par_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fetch_ptr_q != sq_tail) begin
                    state_d    = ST_ISSUE;
                    word_idx_d = 2'd0;
                end
            end
            ST_ISSUE: begin
                if (!sq_wr_active) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sq_rddata_val) begin
                    cmd_data_d = sq_rddata;
                    par_err_d  = par_bad;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cmd_ready) begin
                    if (word_idx_q != last_word) begin
                        word_idx_d = word_idx_q + 2'd1;
                        state_d    = ST_ISSUE;
                    end else begin
                        word_idx_d  = 2'd0;
                        fetch_ptr_d = fetch_ptr_inc;
                        state_d     = (fetch_ptr_inc != sq_tail) ? ST_ISSUE : ST_DOORBELL;
                    end
                end
            end
            ST_DOORBELL: begin
                if (db_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (q_reset) begin
            state_d     = ST_IDLE;
            fetch_ptr_d = '0;
            word_idx_d  = 2'd0;
            par_err_d   = 1'b0;
        end
    end

    // State, pointer and output-word registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            word_idx_q  <= 2'd0;
            fetch_ptr_q <= '0;
            cmd_data_q  <= '0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_idx_q  <= word_idx_d;
            fetch_ptr_q <= fetch_ptr_d;
            cmd_data_q  <= cmd_data_d;
            par_err_q   <= par_err_d;
        end
    end

    // Outputs decoded from state; the read port is yielded to SQ memory writes.
    always_comb begin
        sq_rdval  = (state_q == ST_ISSUE) && !sq_wr_active && !q_reset;
        sq_rdaddr = sq_rdval ? sq_addr_width'({fetch_ptr_q, word_idx_q}) : '0;
        cmd_valid = (state_q == ST_SEND);
        cmd_first = cmd_valid && (word_idx_q == 2'd0);
        cmd_last  = cmd_valid && (word_idx_q == last_word);
        db_req    = (state_q == ST_DOORBELL);
        db_tail   = db_req ? fetch_ptr_q : '0;
        busy      = (state_q != ST_IDLE);
    end

    assign cmd_data  = cmd_data_q;
    assign fetch_ptr = fetch_ptr_q;
    assign par_err   = par_err_q;

endmodule
